fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the `AsyncFifo` among `NUM_REQ` requesters in the write-clock domain. Each requester presents valid/ready/last beats. The arbiter locks a grant for one packet, up to a burst limit, and forwards beats to `wr_en`/`wr_data` while honouring `wr_full`. A hold timeout reclaims the grant from a stalled requester.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 32: beat width; equals the FIFO `DATA_WIDTH`.
- `MAX_BURST`, default 8: maximum beats per grant, ≥1.
- `HOLD_TIMEOUT`, default 16: consecutive granted cycles with `req_valid[g]`=0 before a forced release, ≥1.

Ports:
- `clk`  in  1  single clock, same as the FIFO `wr_clk`.
- `rst`  in  1  **synchronous, active-high reset**.
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_data`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester beat data.
- `req_last`  in  `NUM_REQ`  final beat of the packet.
- `req_ready`  out  `NUM_REQ`  beat accepted when valid&&ready.
- `wr_en`  out  1  to FIFO `wr_en`.
- `wr_data`  out  `DATA_WIDTH`  to FIFO `wr_data`.
- `wr_full`  in  1  from FIFO `wr_full`.
- `grant_id`  out  `$clog2(NUM_REQ)`  current owner; valid only while `busy`=1.
- `busy`  out  1  a grant is held.
- `timeout_evt`  out  1  one-cycle pulse on a timeout release.

## Operation
- FSM states are `IDLE` and `GRANT`.
- **Reset values:**
  - state `IDLE`, `rr_ptr`=`NUM_REQ`-1 (requester 0 wins first), `beat_cnt`=0, `idle_cnt`=0.
  - All outputs are 0, including `req_ready`, `wr_en`, `wr_data`, `grant_id`, `busy` and `timeout_evt`.
- **`IDLE`:**
  - If any `req_valid` is set, pick the first asserted requester scanning `rr_ptr`+1, `rr_ptr`+2, … modulo `NUM_REQ`.
  - Register the winner into `grant_id` and go to `GRANT`.
  - No beats are accepted in `IDLE`.
- **`GRANT`, owner g:**
  - `req_ready[g]` = `!wr_full`; all other `req_ready` bits are 0.
  - `wr_en` = `req_valid[g]` && `!wr_full`.
  - `wr_data` = `req_data[g]`, combinational mux.
  - A beat transfers iff `wr_en`=1. On each transfer, `beat_cnt`++ and `idle_cnt`←0.
- **Release**, back to `IDLE` next cycle, with `rr_ptr`←g, `beat_cnt`←0 and `idle_cnt`←0, on any of:
  - a transfer with `req_last[g]`=1;
  - a transfer that makes `beat_cnt`=`MAX_BURST`; the packet continues in a later grant;
  - `idle_cnt` reaching `HOLD_TIMEOUT`; `timeout_evt`=1 in that same cycle.
- **`idle_cnt` rules:**
  - Increments only when `req_valid[g]`=0 and `wr_full`=0.
  - Holds when `wr_full`=1, because FIFO backpressure never counts against the requester.
- **Widths:**
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `idle_cnt` is `$clog2(HOLD_TIMEOUT+1)` bits.
  - `rr_ptr` is `$clog2(NUM_REQ)` bits; wrap is explicit modulo `NUM_REQ`, which need not be a power of two.
- **Boundary conditions:**
  - `wr_full`=1 freezes all counters.
  - `req_last` together with `beat_cnt`→`MAX_BURST` gives a single release.
  - `req_last` on a beat that is not transferred is ignored.
  - Changes to `req_valid` by requesters other than g do not affect g's grant.
  - `rst` asserted mid-grant aborts the grant immediately. No `wr_en` is issued in the reset cycle.

## Timing
- Arbitration latency: `req_valid` seen in `IDLE` at cycle n → `busy`=1 and first possible `wr_en` at cycle n+1.
- A release at cycle n → `IDLE` at n+1 → next owner at n+2. Exactly one bubble cycle sits between grants.
- `wr_en`, `wr_data` and `req_ready` are combinational from registered state plus `req_valid[g]`, `req_data[g]` and `wr_full`.
  - No path exists from `req_valid` to `req_ready`.
  - `busy`, `grant_id` and `timeout_evt` are registered or state-decoded.
- Maximum throughput: `MAX_BURST` beats per `MAX_BURST`+1 cycles under continuous traffic.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `GRANT`);
  - the helper function `rr_next(ptr, n)` for modulo increment.
- Sub-module `rr_picker` is combinational: inputs are the request vector and `rr_ptr`; outputs are winner index and `any`.
- The FSM, counters and output mux live in `fifo_wr_arbiter`, about 200 lines.

## Test plan
- **Reset priority:** after reset, `req_valid`=4'b1111, each sending 1-beat `last` packets → grants in order 0,1,2,3,0. Each `wr_en` is spaced 2 cycles apart.
- **Burst split:** requester 2 sends 20 beats, last on beat 20, `MAX_BURST`=8, others idle → three grants to 2 of 8, 8 and 4 beats. `wr_data` sequence is preserved, with a 1-cycle bubble between grants.
- **Backpressure:** `wr_full`=1 for 30 cycles during a grant while `req_valid[g]`=1 → `wr_en`=0 and `req_ready`=0 throughout. No timeout occurs, and transfers resume when `wr_full` falls.
- **Timeout:** owner drops `req_valid` for 16 cycles with `HOLD_TIMEOUT`=16 → `timeout_evt` pulses once and `busy` falls next cycle. Requester 1 is granted 2 cycles after the pulse.
- **Reset mid-packet:** `rst` asserted at beat 3 of requester 1 → all outputs are 0 in the following cycle. The next grant goes to requester 0 if it is valid.
- **Fairness:** with `NUM_REQ`=3 and all three valid continuously → grant counts are equal (±1) over 300 cycles.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   rr_next     : modulo-n increment of a round-robin index
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Wraps explicitly so n need not be a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write port, bundled for the arbiter.
//   req_valid/req_data/req_last : per-requester beat offer
//   req_ready                   : per-requester beat accept
//   wr_en/wr_data/wr_full       : FIFO write port
// slave  = arbiter side, master = requesters + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               wr_full;

  modport slave (
    input  req_valid, req_data, req_last, wr_full,
    output req_ready, wr_en, wr_data
  );

  modport master (
    output req_valid, req_data, req_last, wr_full,
    input  req_ready, wr_en, wr_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : last served index; scanning starts at ptr+1
//   winner : first requester found, valid when any=1
//   any    : at least one request is set
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'(rr_next(int'(idx), NUM_REQ));
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant is held for one packet, at most MAX_BURST beats, and is reclaimed
// after HOLD_TIMEOUT granted cycles with no offered beat.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : requester handshake and FIFO write port (slave side)
//   grant_id    : current owner, meaningful while busy=1
//   busy        : a grant is held
//   timeout_evt : one-cycle pulse in the cycle the timeout release happens
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 8,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_wr_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_evt
);
  localparam int GW  = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int IDW = $clog2(HOLD_TIMEOUT + 1);

  arb_state_t     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  rr_q,    rr_d;
  logic [BW-1:0]  beat_q,  beat_d;
  logic [IDW-1:0] idle_q,  idle_d;

  logic [GW-1:0]  pick_idx;
  logic           pick_any;
  logic           live;
  logic           xfer;
  logic           timeout;
  logic           burst_done;
  logic           release_now;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req_valid),
    .ptr    (rr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Reset gates the datapath so a grant aborted by rst issues no write.
  assign live        = (state_q == GRANT) && !rst;
  assign xfer        = live && bus.req_valid[grant_q] && !bus.wr_full;
  assign timeout     = live && (idle_q == IDW'(HOLD_TIMEOUT));
  assign burst_done  = (beat_q + BW'(1)) == BW'(MAX_BURST);
  // A last beat that also fills the burst is still a single release.
  assign release_now = timeout || (xfer && (bus.req_last[grant_q] || burst_done));

  // Outputs: ready depends only on ownership and backpressure, never on req_valid.
  assign bus.wr_en   = xfer;
  assign bus.wr_data = live ? bus.req_data[grant_q] : '0;
  assign busy        = (state_q == GRANT);
  assign grant_id    = grant_q;
  assign timeout_evt = timeout;

  always_comb begin
    bus.req_ready = '0;
    if (live && !bus.wr_full) bus.req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_d = beat_q + BW'(1);
          idle_d = '0;
        end else if (!bus.wr_full) begin
          // Only a silent owner ages; FIFO backpressure freezes the count.
          idle_d = idle_q + IDW'(1);
        end
        if (release_now) begin
          state_d = IDLE;
          rr_d    = grant_q;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= GW'(NUM_REQ - 1);
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end
endmodule
